// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, served from an internal word
// array after a programmable wait, with big-endian byte lanes and error checks.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_dsize,
  input  logic        req_loadext,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // state | meaning
  // IDLE  | ready for a request; captures req_* on accept
  // WAIT  | request held; wait_cnt runs down to 0
  // RESP  | response presented until resp_valid & resp_ready
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        accept;
  logic        enter_resp;

  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_dsize;
  logic        cap_loadext;

  logic        eff_write;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [1:0]  eff_dsize;
  logic        eff_loadext;
  logic [ADDR_WIDTH-1:0] eff_idx;
  logic        eff_err;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [31:0] load_val;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    enter_resp   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 4'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // With zero latency the commit happens on the accept edge, so the live request is used.
  always_comb begin
    if (state == ST_IDLE) begin
      eff_write   = req_write;
      eff_addr    = req_addr;
      eff_wdata   = req_wdata;
      eff_dsize   = req_dsize;
      eff_loadext = req_loadext;
    end else begin
      eff_write   = cap_write;
      eff_addr    = cap_addr;
      eff_wdata   = cap_wdata;
      eff_dsize   = cap_dsize;
      eff_loadext = cap_loadext;
    end
  end

  assign eff_idx = eff_addr[ADDR_WIDTH+1:2];

  always_comb begin
    eff_err = 1'b0;
    if (eff_dsize == 2'b11)                          eff_err = 1'b1;
    if (eff_dsize == 2'b01 && eff_addr[0])           eff_err = 1'b1;
    if (eff_dsize == 2'b10 && eff_addr[1:0] != 2'b00) eff_err = 1'b1;
    if (eff_addr[31:ADDR_WIDTH+2] != '0)             eff_err = 1'b1;
  end

  assign rd_word = mem[eff_idx];

  always_comb begin
    lane_b = 8'h00;
    case (eff_addr[1:0])
      2'd0: lane_b = rd_word[31:24];
      2'd1: lane_b = rd_word[23:16];
      2'd2: lane_b = rd_word[15:8];
      2'd3: lane_b = rd_word[7:0];
      default: lane_b = 8'h00;
    endcase
    lane_h = eff_addr[1] ? rd_word[15:0] : rd_word[31:16];
    case (eff_dsize)
      2'b00:   load_val = eff_loadext ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      2'b01:   load_val = eff_loadext ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default: load_val = rd_word;
    endcase
  end

  // Store merge: only the addressed lanes change.
  always_comb begin
    wr_word = rd_word;
    case (eff_dsize)
      2'b00: begin
        case (eff_addr[1:0])
          2'd0: wr_word[31:24] = eff_wdata[7:0];
          2'd1: wr_word[23:16] = eff_wdata[7:0];
          2'd2: wr_word[15:8]  = eff_wdata[7:0];
          2'd3: wr_word[7:0]   = eff_wdata[7:0];
          default: wr_word = rd_word;
        endcase
      end
      2'b01: begin
        if (eff_addr[1]) wr_word[15:0]  = eff_wdata[15:0];
        else             wr_word[31:16] = eff_wdata[15:0];
      end
      2'b10:   wr_word = eff_wdata;
      default: wr_word = rd_word;
    endcase
  end

  always_ff @(posedge clock) begin
    if (enter_resp && eff_write && !eff_err) mem[eff_idx] <= wr_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      cap_write   <= 1'b0;
      cap_addr    <= 32'h0;
      cap_wdata   <= 32'h0;
      cap_dsize   <= 2'b00;
      cap_loadext <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        cap_write   <= req_write;
        cap_addr    <= req_addr;
        cap_wdata   <= req_wdata;
        cap_dsize   <= req_dsize;
        cap_loadext <= req_loadext;
      end
      if (enter_resp) begin
        resp_err   <= eff_err;
        resp_rdata <= (eff_err || eff_write) ? 32'h0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, ADDR_WIDTH=10): timing,
// byte lanes, extension, errors, backpressure and reset recovery.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_dsize = 2'b10;
  logic        req_loadext = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_vec = 0;
  int n_err = 0;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_dsize(req_dsize),
    .req_loadext(req_loadext), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  // Issue one request; report the response and the edges from accept to resp_valid.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] dsize, input logic ext,
                        output logic [31:0] rdata, output logic err, output int lat);
    int k;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_dsize = dsize; req_loadext = ext;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clock); k++; end
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clock); #1; lat++;
      if (resp_valid) break;
    end
    rdata = resp_rdata; err = resp_err;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_vec++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", resp_err); end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL store_latency got %0d exp 3", lat); end
    n_vec++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL store_ack got %h/%b exp 0/0", rd, er); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL idle_after_store got %b exp 1", req_ready); end
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL load_latency got %0d exp 3", lat); end
    n_vec++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_err++; $display("FAIL load_word got %h/%b exp deadbeef/0", rd, er); end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, rd, er, lat);
    n_vec++; if (rd !== 32'hFFFFFFAD || er !== 1'b0) begin n_err++; $display("FAIL byte_sext got %h/%b exp ffffffad/0", rd, er); end
    do_req(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h000000AD) begin n_err++; $display("FAIL byte_zext got %h exp 000000ad", rd); end
    do_req(1'b0, 32'h10, 32'h0, 2'b01, 1'b1, rd, er, lat);
    n_vec++; if (rd !== 32'hFFFFDEAD) begin n_err++; $display("FAIL half_sext got %h exp ffffdead", rd); end
    do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h000000EF) begin n_err++; $display("FAIL byte3_zext got %h exp 000000ef", rd); end
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b1, rd, er, lat);
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_ext_ignored got %h exp deadbeef", rd); end
  endtask

  task automatic test_store_half;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h12, 32'h00001234, 2'b01, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL half_store_ack got %h/%b exp 0/0", rd, er); end
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'hDEAD1234) begin n_err++; $display("FAIL half_merge got %h exp dead1234", rd); end
    do_req(1'b1, 32'h40, 32'h01234567, 2'b10, 1'b0, rd, er, lat);
    do_req(1'b1, 32'h43, 32'hFFFFFF80, 2'b00, 1'b0, rd, er, lat);
    do_req(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h01234580) begin n_err++; $display("FAIL byte_merge got %h exp 01234580", rd); end
    do_req(1'b0, 32'h42, 32'h0, 2'b01, 1'b1, rd, er, lat);
    n_vec++; if (rd !== 32'h00004580) begin n_err++; $display("FAIL half_pos_sext got %h exp 00004580", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h13, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h0 || er !== 1'b1) begin n_err++; $display("FAIL misaligned_word got %h/%b exp 0/1", rd, er); end
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL err_latency got %0d exp 3", lat); end
    do_req(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h0 || er !== 1'b1) begin n_err++; $display("FAIL misaligned_half got %h/%b exp 0/1", rd, er); end
    do_req(1'b1, 32'h00001000, 32'h55, 2'b00, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h0 || er !== 1'b1) begin n_err++; $display("FAIL out_of_range got %h/%b exp 0/1", rd, er); end
    do_req(1'b1, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h0 || er !== 1'b1) begin n_err++; $display("FAIL dsize_reserved got %h/%b exp 0/1", rd, er); end
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'hDEAD1234 || er !== 1'b0) begin n_err++; $display("FAIL no_update_on_err got %h/%b exp dead1234/0", rd, er); end
    do_req(1'b0, 32'h00000FFC, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL top_in_range got %b exp 0", er); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat; int k;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_dsize = 2'b10; req_loadext = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 50) begin @(posedge clock); #1; k++; end
    n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_resp_timeout got %b exp 1", resp_valid); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0; req_addr = 32'h10; req_dsize = 2'b10;
      end else begin
        req_valid = 1'b0;
      end
      n_vec++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD1234 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cyc %0d got v=%b d=%h e=%b rr=%b exp 1/dead1234/0/0",
                 c, resp_valid, resp_rdata, resp_err, req_ready);
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got rr=%b v=%b exp 1/0", req_ready, resp_valid); end
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'hDEAD1234) begin n_err++; $display("FAIL bp_ignored_req got %h exp dead1234", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h20, 32'hAAAA5555, 2'b10, 1'b0, rd, er, lat);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1; req_dsize = 2'b10;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #2;
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL wait_reset_valid got %b exp 0", resp_valid); end
    #2 reset = 1'b1;
    @(negedge clock);
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL wait_reset_state got rr=%b v=%b exp 1/0", req_ready, resp_valid); end
    do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'hAAAA5555) begin n_err++; $display("FAIL wait_abort_store got %h exp aaaa5555", rd); end
    // Reset while the store response is pending: store already committed.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h0000005A; req_dsize = 2'b10;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL resp_before_reset got %b exp 1", resp_valid); end
    reset = 1'b0;
    #2;
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL resp_reset_drop got %b exp 0", resp_valid); end
    #2 reset = 1'b1;
    do_req(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_vec++; if (rd !== 32'h0000005A) begin n_err++; $display("FAIL resp_store_kept got %h exp 0000005a", rd); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_subword;
    test_store_half;
    test_errors;
    test_backpressure;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
